// File: rtl/elevator_ctrl.sv
// Single-car SCAN elevator controller: latches floor calls, steps the car one floor per
// MOVE_TICKS ticks, runs the door cycle and counts occupants. Optional macro: OVERLOAD_EN.
module elevator_ctrl #(
    parameter int NUM_FLOORS = 8,
    parameter int MAX_PEOPLE = 15,
    parameter int MOVE_TICKS = 2,
    parameter int DOOR_TICKS = 4,
    parameter int LOAD_LIMIT = 10,
    localparam int PW = $clog2(MAX_PEOPLE + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tick,
    input  logic [NUM_FLOORS-1:0] req,
    input  logic                  add,
    input  logic                  rem,
    input  logic                  close,
    output logic [PW-1:0]         people,
    output logic [NUM_FLOORS-1:0] floor,
    output logic                  dir,
    output logic                  open,
    output logic                  overload
);

    localparam int MW = $clog2(MOVE_TICKS + 1);
    localparam int DW = $clog2(DOOR_TICKS + 1);
    localparam logic [MW-1:0]         MOVE_LAST = MW'(MOVE_TICKS);
    localparam logic [DW-1:0]         DOOR_LAST = DW'(DOOR_TICKS);
    localparam logic [PW-1:0]         PEOPLE_MAX = PW'(MAX_PEOPLE);
    localparam logic [NUM_FLOORS-1:0] ONE_F = {{(NUM_FLOORS-1){1'b0}}, 1'b1};

    if (NUM_FLOORS < 2 || MOVE_TICKS < 1 || DOOR_TICKS < 1 || LOAD_LIMIT < 0) begin : g_bad_params
        $error("elevator_ctrl: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        DOOR = 2'd2
    } state_t;

    state_t                  state_r;
    logic [NUM_FLOORS-1:0]   pending_r;
    logic [NUM_FLOORS-1:0]   floor_r;
    logic                    dir_r;
    logic                    open_r;
    logic [PW-1:0]           people_r;
    logic                    overload_r;
    logic [MW-1:0]           mcnt_r;
    logic [DW-1:0]           dcnt_r;

    logic [NUM_FLOORS-1:0]   latch_s;
    logic [NUM_FLOORS-1:0]   step_s;
    logic                    at_end_s;
    logic                    ahead_s;
    logic                    behind_s;
    logic [PW-1:0]           people_nx_s;
    logic                    hold_s;

    // Calls strictly beyond a one-hot floor in the given direction.
    function automatic logic calls_ahead(input logic [NUM_FLOORS-1:0] pend,
                                         input logic [NUM_FLOORS-1:0] fl,
                                         input logic                  up);
        logic [NUM_FLOORS-1:0] below;
        below = fl - ONE_F;
        if (up) begin
            return |(pend & ~(fl | below));
        end else begin
            return |(pend & below);
        end
    endfunction

    assign latch_s  = pending_r | (req & ~(open_r ? floor_r : {NUM_FLOORS{1'b0}}));
    assign step_s   = dir_r ? {floor_r[NUM_FLOORS-2:0], 1'b0} : {1'b0, floor_r[NUM_FLOORS-1:1]};
    assign at_end_s = dir_r ? floor_r[NUM_FLOORS-1] : floor_r[0];
    assign ahead_s  = calls_ahead(pending_r, floor_r, dir_r);
    assign behind_s = calls_ahead(pending_r, floor_r, ~dir_r);

`ifdef OVERLOAD_EN
    assign hold_s = overload_r;
`else
    assign hold_s = 1'b0;
`endif

    // Occupant count: buttons only count with the door open; simultaneous add/rem cancel.
    always_comb begin
        people_nx_s = people_r;
        if (open_r) begin
            case ({add, rem})
                2'b10: begin
                    if (people_r != PEOPLE_MAX) begin
                        people_nx_s = people_r + {{(PW-1){1'b0}}, 1'b1};
                    end else begin
                        people_nx_s = people_r;
                    end
                end
                2'b01: begin
                    if (people_r != {PW{1'b0}}) begin
                        people_nx_s = people_r - {{(PW-1){1'b0}}, 1'b1};
                    end else begin
                        people_nx_s = people_r;
                    end
                end
                default: people_nx_s = people_r;
            endcase
        end else begin
            people_nx_s = people_r;
        end
    end

    // Main controller: call latching, SCAN travel, door cycle and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            pending_r  <= {NUM_FLOORS{1'b0}};
            floor_r    <= ONE_F;
            dir_r      <= 1'b1;
            open_r     <= 1'b0;
            people_r   <= {PW{1'b0}};
            overload_r <= 1'b0;
            mcnt_r     <= {MW{1'b0}};
            dcnt_r     <= {DW{1'b0}};
        end else begin
            pending_r <= latch_s;
            people_r  <= people_nx_s;
`ifdef OVERLOAD_EN
            overload_r <= (int'(people_nx_s) > LOAD_LIMIT);
`else
            overload_r <= 1'b0;
`endif
            case (state_r)
                IDLE: begin
                    if (|(pending_r & floor_r)) begin
                        pending_r <= latch_s & ~floor_r;
                        state_r   <= DOOR;
                        open_r    <= 1'b1;
                        dcnt_r    <= {DW{1'b0}};
                    end else if (ahead_s) begin
                        state_r <= MOVE;
                        mcnt_r  <= {MW{1'b0}};
                    end else if (behind_s) begin
                        dir_r   <= ~dir_r;
                        state_r <= MOVE;
                        mcnt_r  <= {MW{1'b0}};
                    end else begin
                        state_r <= IDLE;
                    end
                end
                MOVE: begin
                    if (tick) begin
                        if (mcnt_r + {{(MW-1){1'b0}}, 1'b1} == MOVE_LAST) begin
                            mcnt_r <= {MW{1'b0}};
                            // The end-stop guard keeps the car from shifting off the shaft.
                            if (at_end_s) begin
                                state_r <= IDLE;
                            end else if (|(pending_r & step_s)) begin
                                floor_r   <= step_s;
                                pending_r <= latch_s & ~step_s;
                                state_r   <= DOOR;
                                open_r    <= 1'b1;
                                dcnt_r    <= {DW{1'b0}};
                            end else if (calls_ahead(pending_r, step_s, dir_r)) begin
                                floor_r <= step_s;
                                state_r <= MOVE;
                            end else begin
                                floor_r <= step_s;
                                state_r <= IDLE;
                            end
                        end else begin
                            mcnt_r <= mcnt_r + {{(MW-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        mcnt_r <= mcnt_r;
                    end
                end
                DOOR: begin
                    if (close && !hold_s) begin
                        state_r <= IDLE;
                        open_r  <= 1'b0;
                    end else if (hold_s || add || rem) begin
                        dcnt_r <= {DW{1'b0}};
                    end else if (tick) begin
                        if (dcnt_r + {{(DW-1){1'b0}}, 1'b1} == DOOR_LAST) begin
                            state_r <= IDLE;
                            open_r  <= 1'b0;
                        end else begin
                            dcnt_r <= dcnt_r + {{(DW-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        dcnt_r <= dcnt_r;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    open_r  <= 1'b0;
                end
            endcase
        end
    end

    assign people   = people_r;
    assign floor    = floor_r;
    assign dir      = dir_r;
    assign open     = open_r;
    assign overload = overload_r;

endmodule

// File: tb/tb_elevator_ctrl.sv
// Directed bench for elevator_ctrl (default parameters): a per-cycle vector table for reset
// and a single call, then hand sequences for SCAN order, end floors, occupancy and door timing.
module tb_elevator_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic [7:0] req = 8'h00;
    logic       add = 1'b0;
    logic       rem = 1'b0;
    logic       close = 1'b0;
    logic [3:0] people;
    logic [7:0] floor;
    logic       dir;
    logic       open;
    logic       overload;

    int n_cmp = 0;
    int n_bad = 0;

    elevator_ctrl dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .req(req), .add(add), .rem(rem),
        .close(close), .people(people), .floor(floor), .dir(dir), .open(open),
        .overload(overload)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       tick;
        logic [7:0] req;
        logic       add;
        logic       rem;
        logic       close;
        logic [7:0] e_floor;
        logic       e_dir;
        logic       e_open;
        logic [3:0] e_people;
    } vec_t;

    vec_t tbl[20];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One clock with the given inputs; pulses drop again after the edge.
    task automatic clk1(input logic t, input logic a, input logic r, input logic c,
                        input logic [7:0] q);
        tick = t; add = a; rem = r; close = c; req = q;
        @(posedge clk);
        #1;
        tick = 1'b0; add = 1'b0; rem = 1'b0; close = 1'b0; req = 8'h00;
    endtask

    task automatic wait_open(input int budget, input string nm);
        int n = 0;
        while (open !== 1'b1 && n < budget) begin
            clk1(n[0] == 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
            n++;
        end
        chk({nm, "_open"}, {31'd0, open}, 32'd1);
    endtask

    task automatic wait_closed(input int budget, input string nm);
        int n = 0;
        while (open !== 1'b0 && n < budget) begin
            clk1(n[0] == 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
            n++;
        end
        chk({nm, "_closed"}, {31'd0, open}, 32'd0);
    endtask

    task automatic idle_run(input int cycles, input logic [7:0] exp_floor, input string nm);
        int opens = 0;
        for (int i = 0; i < cycles; i++) begin
            clk1(i[0] == 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
            if (open === 1'b1) opens++;
        end
        chk({nm, "_no_reopen"}, opens, 32'd0);
        chk({nm, "_floor"}, {24'd0, floor}, {24'd0, exp_floor});
    endtask

    initial begin
        //          rst  tk  req    add  rem  cls   floor  dir  open ppl
        tbl[0]  = '{1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 4'd0};
        tbl[1]  = '{1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 4'd0};
        tbl[2]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 4'd0};
        tbl[3]  = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 4'd0};
        tbl[4]  = '{1'b1, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 4'd0};
        tbl[5]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 4'd0};
        tbl[6]  = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 4'd0};
        tbl[7]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 4'd0};
        tbl[8]  = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h02, 1'b1, 1'b0, 4'd0};
        tbl[9]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h02, 1'b1, 1'b0, 4'd0};
        tbl[10] = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h02, 1'b1, 1'b0, 4'd0};
        tbl[11] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h02, 1'b1, 1'b0, 4'd0};
        tbl[12] = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h04, 1'b1, 1'b0, 4'd0};
        tbl[13] = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h04, 1'b1, 1'b0, 4'd0};
        tbl[14] = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h08, 1'b1, 1'b1, 4'd0};
        tbl[15] = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h08, 1'b1, 1'b1, 4'd0};
        tbl[16] = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h08, 1'b1, 1'b1, 4'd0};
        tbl[17] = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h08, 1'b1, 1'b1, 4'd0};
        tbl[18] = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h08, 1'b1, 1'b0, 4'd0};
        tbl[19] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h08, 1'b1, 1'b0, 4'd0};

        for (int i = 0; i < 20; i++) begin
            rst_n = tbl[i].rst_n; tick = tbl[i].tick; req = tbl[i].req;
            add = tbl[i].add; rem = tbl[i].rem; close = tbl[i].close;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_floor", i), {24'd0, floor}, {24'd0, tbl[i].e_floor});
            chk($sformatf("vec%0d_dir", i), {31'd0, dir}, {31'd0, tbl[i].e_dir});
            chk($sformatf("vec%0d_open", i), {31'd0, open}, {31'd0, tbl[i].e_open});
            chk($sformatf("vec%0d_people", i), {28'd0, people}, {28'd0, tbl[i].e_people});
            chk($sformatf("vec%0d_overload", i), {31'd0, overload}, 32'd0);
        end

        // SCAN: car idle at floor 3 heading up, calls at 1 and 6.
        clk1(1'b0, 1'b0, 1'b0, 1'b0, 8'h42);
        wait_open(60, "scan_up");
        chk("scan_up_floor", {24'd0, floor}, 32'h40);
        chk("scan_up_dir", {31'd0, dir}, 32'd1);
        wait_closed(20, "scan_up");
        wait_open(80, "scan_down");
        chk("scan_down_floor", {24'd0, floor}, 32'h02);
        chk("scan_down_dir", {31'd0, dir}, 32'd0);
        wait_closed(20, "scan_down");
        idle_run(20, 8'h02, "scan_done");

        // Top floor; a call for the current floor while the door is open is dropped.
        clk1(1'b0, 1'b0, 1'b0, 1'b0, 8'h80);
        wait_open(80, "top");
        chk("top_floor", {24'd0, floor}, 32'h80);
        chk("top_dir", {31'd0, dir}, 32'd1);
        clk1(1'b0, 1'b0, 1'b0, 1'b0, 8'h80);
        wait_closed(20, "top");
        idle_run(20, 8'h80, "top_done");
        chk("top_dir_kept", {31'd0, dir}, 32'd1);

        // Bottom floor.
        clk1(1'b0, 1'b0, 1'b0, 1'b0, 8'h01);
        wait_open(80, "bottom");
        chk("bottom_floor", {24'd0, floor}, 32'h01);
        chk("bottom_dir", {31'd0, dir}, 32'd0);

        // Occupancy with the door held open (no ticks).
        for (int i = 0; i < 16; i++) begin
            clk1(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
            chk($sformatf("add%0d", i), {28'd0, people}, (i < 15) ? i + 1 : 15);
        end
        clk1(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        chk("add_rem_same", {28'd0, people}, 32'd15);
        for (int i = 0; i < 16; i++) begin
            clk1(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
            chk($sformatf("rem%0d", i), {28'd0, people}, (i < 15) ? 14 - i : 0);
        end
        clk1(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("occ_close", {31'd0, open}, 32'd0);
        clk1(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("add_closed", {28'd0, people}, 32'd0);

        // Door hold: add on the third tick restarts the four-tick timeout.
        clk1(1'b0, 1'b0, 1'b0, 1'b0, 8'h01);
        wait_open(10, "hold");
        clk1(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        clk1(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        clk1(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("hold_people", {28'd0, people}, 32'd1);
        for (int i = 0; i < 3; i++) clk1(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("hold_still_open", {31'd0, open}, 32'd1);
        clk1(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("hold_timeout", {31'd0, open}, 32'd0);

        // Close coincident with a tick.
        clk1(1'b0, 1'b0, 1'b0, 1'b0, 8'h01);
        wait_open(10, "close_tick");
        clk1(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("close_tick", {31'd0, open}, 32'd0);

        // Load above LOAD_LIMIT.
        clk1(1'b0, 1'b0, 1'b0, 1'b0, 8'h01);
        wait_open(10, "load");
        for (int i = 0; i < 10; i++) clk1(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("load_people", {28'd0, people}, 32'd11);
`ifdef OVERLOAD_EN
        chk("load_overload", {31'd0, overload}, 32'd1);
        for (int i = 0; i < 10; i++) clk1(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("load_held_open", {31'd0, open}, 32'd1);
        clk1(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("load_rem_overload", {31'd0, overload}, 32'd0);
        clk1(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("load_close", {31'd0, open}, 32'd0);
`else
        chk("load_overload", {31'd0, overload}, 32'd0);
        clk1(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("load_close", {31'd0, open}, 32'd0);
        chk("load_overload_after", {31'd0, overload}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
